// File: rtl/act_delay_line.sv
// Dilated activation cache: ring buffer of 3*DILATION+1 packed vectors feeding four
// registered taps. Optional build macro ACT_DELAY_LINE_RELU_EN clamps negative lanes on write.
module act_delay_line #(
    parameter int unsigned W        = 16,
    parameter int unsigned D        = 8,
    parameter int unsigned DILATION = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_v,
    input  logic [D*W-1:0]   inp,
    output logic [D*W-1:0]   out_l0,
    output logic [D*W-1:0]   out_l1,
    output logic [D*W-1:0]   out_l2,
    output logic [D*W-1:0]   out_l3,
    output logic             out_v,
    output logic             primed
);

    localparam int unsigned VecW  = D * W;
    localparam int unsigned Depth = 3 * DILATION + 1;
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned FillW = $clog2(Depth + 1);

    logic [VecW-1:0]  mem_q [Depth];
    logic [AddrW-1:0] wp_q, wp_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic [VecW-1:0]  l0_q, l0_d, l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
    logic             out_v_q, out_v_d;
    logic             primed_q, primed_d;

    logic [VecW-1:0]  wr_data;
    logic [AddrW-1:0] addr_l2, addr_l1, addr_l0;

    // Slot written "back" writes before wp, modulo Depth, without a divider.
    function automatic logic [AddrW-1:0] tap_addr(input logic [AddrW-1:0] wp,
                                                  input int unsigned back);
        int unsigned t;
        t = 32'(wp) + Depth - back;
        if (t >= Depth) begin
            t = t - Depth;
        end
        return AddrW'(t);
    endfunction

`ifdef ACT_DELAY_LINE_RELU_EN
    always_comb begin
        wr_data = inp;
        for (int i = 0; i < int'(D); i++) begin
            if (inp[i*W + W - 1]) begin
                wr_data[i*W +: W] = '0;
            end
        end
    end
`else
    assign wr_data = inp;
`endif

    assign addr_l2 = tap_addr(wp_q, DILATION);
    assign addr_l1 = tap_addr(wp_q, 2 * DILATION);
    assign addr_l0 = tap_addr(wp_q, 3 * DILATION);

    always_comb begin
        wp_d     = wp_q;
        fill_d   = fill_q;
        l0_d     = l0_q;
        l1_d     = l1_q;
        l2_d     = l2_q;
        l3_d     = l3_q;
        out_v_d  = 1'b0;
        primed_d = primed_q;
        if (clear) begin
            wp_d     = '0;
            fill_d   = '0;
            l0_d     = '0;
            l1_d     = '0;
            l2_d     = '0;
            l3_d     = '0;
            primed_d = 1'b0;
        end else if (in_v) begin
            wp_d    = (wp_q == AddrW'(Depth - 1)) ? '0 : wp_q + AddrW'(1);
            fill_d  = (fill_q == FillW'(Depth)) ? fill_q : fill_q + FillW'(1);
            // Older taps read slots other than wp_q, so the old contents are still valid here.
            l3_d     = wr_data;
            l2_d     = mem_q[addr_l2];
            l1_d     = mem_q[addr_l1];
            l0_d     = mem_q[addr_l0];
            out_v_d  = 1'b1;
            primed_d = (fill_d == FillW'(Depth));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q     <= '0;
            fill_q   <= '0;
            l0_q     <= '0;
            l1_q     <= '0;
            l2_q     <= '0;
            l3_q     <= '0;
            out_v_q  <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            fill_q   <= fill_d;
            l0_q     <= l0_d;
            l1_q     <= l1_d;
            l2_q     <= l2_d;
            l3_q     <= l3_d;
            out_v_q  <= out_v_d;
            primed_q <= primed_d;
        end
    end

    // Zeroed storage provides causal zero-padding before the line is primed.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (in_v) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    assign out_l0 = l0_q;
    assign out_l1 = l1_q;
    assign out_l2 = l2_q;
    assign out_l3 = l3_q;
    assign out_v  = out_v_q;
    assign primed = primed_q;

endmodule

// File: tb/tb_act_delay_line.sv
// Bench for act_delay_line: history-list model checked every cycle, plus directed literal checks.
// Honours ACT_DELAY_LINE_RELU_EN in the model when defined.
module tb_act_delay_line;

    localparam int unsigned W     = 16;
    localparam int unsigned D     = 8;
    localparam int unsigned DIL   = 4;
    localparam int unsigned DW    = D * W;
    localparam int unsigned DEPTH = 3 * DIL + 1;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_v;
    logic [DW-1:0] inp;
    logic [DW-1:0] out_l0, out_l1, out_l2, out_l3;
    logic          out_v, primed;

    int n_checks = 0;
    int n_pass   = 0;

    act_delay_line #(.W(W), .D(D), .DILATION(DIL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .in_v   (in_v),
        .inp    (inp),
        .out_l0 (out_l0),
        .out_l1 (out_l1),
        .out_l2 (out_l2),
        .out_l3 (out_l3),
        .out_v  (out_v),
        .primed (primed)
    );

    always #5 clk = ~clk;

    task automatic chk_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    function automatic int lane(input logic [DW-1:0] v, input int i);
        logic signed [W-1:0] x;
        x = v[(int'(D) - i) * int'(W) - 1 -: W];
        return int'(x);
    endfunction

    function automatic logic [DW-1:0] set_lane(input logic [DW-1:0] v, input int i, input int val);
        logic [DW-1:0] r;
        r = v;
        r[(int'(D) - i) * int'(W) - 1 -: W] = W'(val);
        return r;
    endfunction

    function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
`ifdef ACT_DELAY_LINE_RELU_EN
        for (int i = 0; i < int'(D); i++) begin
            if (lane(v, i) < 0) r = set_lane(r, i, 0);
        end
`endif
        return r;
    endfunction

    // Model: list of stored vectors since last reset/clear, newest at the back.
    logic [DW-1:0] hist[$];
    int            n_writes;
    logic [DW-1:0] e_l0, e_l1, e_l2, e_l3;
    logic          e_v, e_pr;
    bit            started = 1'b0;

    function automatic logic [DW-1:0] model_tap(input int k);
        int idx;
        idx = int'(hist.size()) - 1 - k * int'(DIL);
        if (idx >= 0) return hist[idx];
        return '0;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n || clear) begin
            hist.delete();
            n_writes = 0;
            e_l0 = '0; e_l1 = '0; e_l2 = '0; e_l3 = '0;
            e_v = 1'b0;
            e_pr = 1'b0;
        end else if (in_v) begin
            hist.push_back(relu_m(inp));
            if (hist.size() > DEPTH) void'(hist.pop_front());
            n_writes++;
            e_l3 = model_tap(0);
            e_l2 = model_tap(1);
            e_l1 = model_tap(2);
            e_l0 = model_tap(3);
            e_v  = 1'b1;
            e_pr = (n_writes >= int'(DEPTH));
        end else begin
            e_v = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk_vec("model_out_l3", out_l3, e_l3);
            chk_vec("model_out_l2", out_l2, e_l2);
            chk_vec("model_out_l1", out_l1, e_l1);
            chk_vec("model_out_l0", out_l0, e_l0);
            chk_bit("model_out_v", out_v, e_v);
            chk_bit("model_primed", primed, e_pr);
        end
    end

    task automatic step(input logic r, input logic c, input logic v, input logic [DW-1:0] d);
        rst_n = r;
        clear = c;
        in_v  = v;
        inp   = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane0_vec(input int val);
        return set_lane('0, 0, val);
    endfunction

    initial begin
        logic [DW-1:0] all_max, v, exp_relu;
        rst_n = 1'b0; clear = 1'b0; in_v = 1'b0; inp = '0;
        all_max = '0;
        for (int i = 0; i < int'(D); i++) all_max = set_lane(all_max, i, 16'h7FFF);

        // Reset held with write strobe active
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, 1'b1, all_max);
            chk_vec("rst_l3", out_l3, '0);
            chk_vec("rst_l0", out_l0, '0);
            chk_bit("rst_out_v", out_v, 1'b0);
            chk_bit("rst_primed", primed, 1'b0);
        end
        step(1'b1, 1'b0, 1'b1, all_max);
        chk_vec("first_l3", out_l3, all_max);
        chk_vec("first_l2", out_l2, '0);
        chk_vec("first_l1", out_l1, '0);
        chk_vec("first_l0", out_l0, '0);
        chk_bit("first_out_v", out_v, 1'b1);

        // Dilation ordering
        step(1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 13; k++) begin
            step(1'b1, 1'b0, 1'b1, lane0_vec(k));
            if (k == 12) begin
                chk_int("dil_w12_l0", lane(out_l0, 0), 0);
                chk_bit("dil_w12_primed", primed, 1'b0);
            end
        end
        chk_int("dil_l3", lane(out_l3, 0), 13);
        chk_int("dil_l2", lane(out_l2, 0), 9);
        chk_int("dil_l1", lane(out_l1, 0), 5);
        chk_int("dil_l0", lane(out_l0, 0), 1);
        chk_bit("dil_primed", primed, 1'b1);

        // Full rate with wrap-around
        step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 1'b1, lane0_vec(i));
            chk_bit("full_out_v", out_v, 1'b1);
            if (i >= 13) chk_int("full_diff", lane(out_l3, 0) - lane(out_l0, 0), 12);
        end

        // Clear collides with a write
        chk_bit("pre_clear_primed", primed, 1'b1);
        step(1'b1, 1'b1, 1'b1, lane0_vec(99));
        chk_vec("clr_l3", out_l3, '0);
        chk_vec("clr_l0", out_l0, '0);
        chk_bit("clr_out_v", out_v, 1'b0);
        chk_bit("clr_primed", primed, 1'b0);
        step(1'b1, 1'b0, 1'b1, lane0_vec(5));
        chk_int("clr_next_l3", lane(out_l3, 0), 5);
        chk_int("clr_next_l2", lane(out_l2, 0), 0);

        // Negative lanes
        v = '0;
        v = set_lane(v, 0, -3);
        v = set_lane(v, 1, 7);
        v = set_lane(v, 2, -32768);
`ifdef ACT_DELAY_LINE_RELU_EN
        exp_relu = set_lane('0, 1, 7);
`else
        exp_relu = v;
`endif
        step(1'b1, 1'b0, 1'b1, v);
        chk_vec("relu_l3", out_l3, exp_relu);

        // Reset mid-stream
        step(1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 1'b1, lane0_vec(k + 40));
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, lane0_vec(1));
        chk_int("mid_l3", lane(out_l3, 0), 1);
        chk_vec("mid_l2", out_l2, '0);
        chk_vec("mid_l1", out_l1, '0);
        chk_vec("mid_l0", out_l0, '0);
        chk_bit("mid_primed", primed, 1'b0);

        // Randomized traffic, checked by the per-cycle model compare
        for (int c = 0; c < 2000; c++) begin
            v = '0;
            for (int i = 0; i < int'(D); i++) v[i*W +: W] = W'($urandom);
            step(($urandom_range(99) != 0), ($urandom_range(31) == 0),
                 ($urandom_range(9) < 6), v);
        end

        step(1'b1, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
